// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered issue stage in front of the ALU.
// Holds up to two decoded instructions (HEAD drives the ALU, SKID absorbs one
// extra instruction while execute stalls) behind valid/ready handshakes.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   -> write-back results patch matching rs1/rs2 values, both at
//                capture and in held entries (address 0 never patched)
//   undefined -> fwd_* inputs are ignored
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           decode-side handshake
//   in_rs1_val .. in_op_sel       decoded instruction payload
//   flush                         drop every held entry and any incoming one
//   fwd_valid/fwd_rd_addr/fwd_data write-back result for forwarding
//   out_valid / out_ready         execute-side handshake
//   opd1..opd4, alu_*_select      ALU operands and control from HEAD
//   out_rd_addr, out_rd_we        destination passed downstream
module alu_issue_stage #(
  parameter int unsigned OPERAND_LENGTH = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_LENGTH-1:0] in_rs1_val,
  input  logic [OPERAND_LENGTH-1:0] in_rs2_val,
  input  logic [OPERAND_LENGTH-1:0] in_pc,
  input  logic [OPERAND_LENGTH-1:0] in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_rd_we,
  input  logic                      in_use_pc,
  input  logic                      in_use_imm,
  input  logic                      in_mux1_sel,
  input  logic [1:0]                in_mux2_sel,
  input  logic [2:0]                in_op_sel,
  input  logic                      flush,
  input  logic                      fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_rd_addr,
  input  logic [OPERAND_LENGTH-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_LENGTH-1:0] opd1,
  output logic [OPERAND_LENGTH-1:0] opd2,
  output logic [OPERAND_LENGTH-1:0] opd3,
  output logic [OPERAND_LENGTH-1:0] opd4,
  output logic                      alu_mux1_select,
  output logic [1:0]                alu_mux2_select,
  output logic [2:0]                alu_op_select,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_rd_we
);

  localparam int unsigned DW = OPERAND_LENGTH;
  localparam int unsigned AW = REG_ADDR_WIDTH;

  // One buffered instruction
  typedef struct packed {
    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_we;
    logic          use_pc;
    logic          use_imm;
    logic          mux1_sel;
    logic [1:0]    mux2_sel;
    logic [2:0]    op_sel;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  entry_t in_fwd, head_fwd, skid_fwd;
  logic   accept, pop;

  // Pack incoming decode fields
  always_comb begin
    in_entry          = '0;
    in_entry.rs1_val  = in_rs1_val;
    in_entry.rs2_val  = in_rs2_val;
    in_entry.pc       = in_pc;
    in_entry.imm      = in_imm;
    in_entry.rs1_addr = in_rs1_addr;
    in_entry.rs2_addr = in_rs2_addr;
    in_entry.rd_addr  = in_rd_addr;
    in_entry.rd_we    = in_rd_we;
    in_entry.use_pc   = in_use_pc;
    in_entry.use_imm  = in_use_imm;
    in_entry.mux1_sel = in_mux1_sel;
    in_entry.mux2_sel = in_mux2_sel;
    in_entry.op_sel   = in_op_sel;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Replace stale register values with the result being written back
  function automatic entry_t fwd_patch(input entry_t e, input logic v,
                                       input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    entry_t r;
    r = e;
    if (v && (a != '0)) begin
      if (e.rs1_addr == a) r.rs1_val = d;
      if (e.rs2_addr == a) r.rs2_val = d;
    end
    return r;
  endfunction

  // Patching an invalid entry is harmless: it is never observed or promoted
  assign in_fwd   = fwd_patch(in_entry, fwd_valid, fwd_rd_addr, fwd_data);
  assign head_fwd = fwd_patch(head_q, fwd_valid, fwd_rd_addr, fwd_data);
  assign skid_fwd = fwd_patch(skid_q, fwd_valid, fwd_rd_addr, fwd_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd_addr, fwd_data};
  assign in_fwd     = in_entry;
  assign head_fwd   = head_q;
  assign skid_fwd   = skid_q;
`endif

  // Ready depends on registered state only, never on out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy next-state and entry movement
  always_comb begin
    state_d = state_q;
    head_d  = head_fwd;
    skid_d  = skid_fwd;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_fwd;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = in_fwd;
          end else if (accept) begin
            skid_d  = in_fwd;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_fwd;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ALU-facing view of HEAD
  assign opd1            = head_q.use_pc  ? head_q.pc  : head_q.rs1_val;
  assign opd2            = head_q.use_imm ? head_q.imm : head_q.rs2_val;
  assign opd3            = head_q.rs1_val;
  assign opd4            = head_q.rs2_val;
  assign alu_mux1_select = head_q.mux1_sel;
  assign alu_mux2_select = head_q.mux2_sel;
  assign alu_op_select   = head_q.op_sel;
  assign out_rd_addr     = head_q.rd_addr;
  assign out_rd_we       = head_q.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Forwarding expectations follow
// ALU_ISSUE_FWD_EN so the bench matches whichever build it is compiled with.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_val, in_rs2_val, in_pc, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_rd_we, in_use_pc, in_use_imm, in_mux1_sel;
  logic [1:0]  in_mux2_sel;
  logic [2:0]  in_op_sel;
  logic        flush;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] opd1, opd2, opd3, opd4;
  logic        alu_mux1_select;
  logic [1:0]  alu_mux2_select;
  logic [2:0]  alu_op_select;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;

  int total  = 0;
  int passed = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
    .in_mux1_sel(in_mux1_sel), .in_mux2_sel(in_mux2_sel), .in_op_sel(in_op_sel),
    .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opd1(opd1), .opd2(opd2), .opd3(opd3), .opd4(opd4),
    .alu_mux1_select(alu_mux1_select), .alu_mux2_select(alu_mux2_select),
    .alu_op_select(alu_op_select),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clear_in();
    in_valid = 0; in_rs1_val = '0; in_rs2_val = '0; in_pc = '0; in_imm = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0; in_rd_we = 0;
    in_use_pc = 0; in_use_imm = 0; in_mux1_sel = 0; in_mux2_sel = '0; in_op_sel = '0;
  endtask

  task automatic offer(input logic [31:0] r1, input logic [31:0] r2);
    clear_in();
    in_valid = 1; in_rs1_val = r1; in_rs2_val = r2;
  endtask

  initial begin
    clear_in();
    flush = 0; fwd_valid = 0; fwd_rd_addr = '0; fwd_data = '0; out_ready = 0;

    // Reset, with a handshake offered during reset that must be ignored
    rst = 1;
    offer(32'hDEAD, 32'hBEEF);
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_opd1", opd1, 32'd0);
    check("rst_opd4", opd4, 32'd0);
    check("rst_ctrl", {24'd0, alu_op_select, alu_mux2_select, alu_mux1_select, out_rd_we}, 32'd0);
    rst = 0;
    clear_in();
    step();
    check("post_rst_empty", 32'(out_valid), 32'd0);

    // Single issue
    out_ready = 1;
    offer(32'd3, 32'd8);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_opd1", opd1, 32'd3);
    check("single_opd2", opd2, 32'd8);
    check("single_opd3", opd3, 32'd3);
    check("single_opd4", opd4, 32'd8);
    clear_in();
    step();
    check("single_drain", 32'(out_valid), 32'd0);

    // Stall: two accepted, third held off, then drained in order
    out_ready = 0;
    offer(32'h11, 32'h12);
    step();
    check("stall_a_ready", 32'(in_ready), 32'd1);
    offer(32'h21, 32'h22);
    in_op_sel = 3'd5; in_mux2_sel = 2'd2; in_mux1_sel = 1;
    step();
    check("stall_full_ready", 32'(in_ready), 32'd0);
    check("stall_head_a", opd1, 32'h11);
    offer(32'h31, 32'h32);
    step();
    check("stall_hold_ready", 32'(in_ready), 32'd0);
    check("stall_hold_head", opd3, 32'h11);
    out_ready = 1;
    step();
    check("drain_b_opd1", opd1, 32'h21);
    check("drain_b_ctrl", {27'd0, alu_op_select, alu_mux2_select}, {27'd0, 3'd5, 2'd2});
    check("drain_b_mux1", 32'(alu_mux1_select), 32'd1);
    check("drain_b_ready", 32'(in_ready), 32'd1);
    step();
    check("drain_c_opd1", opd1, 32'h31);
    check("drain_c_valid", 32'(out_valid), 32'd1);
    clear_in();
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // PC / immediate select
    clear_in();
    in_valid = 1; in_use_pc = 1; in_pc = 32'h100; in_use_imm = 1; in_imm = 32'h0C;
    in_rs1_val = 32'd5; in_rs2_val = 32'd7; in_rd_addr = 5'd9; in_rd_we = 1;
    step();
    check("sel_opd1", opd1, 32'h100);
    check("sel_opd2", opd2, 32'h0C);
    check("sel_opd3", opd3, 32'd5);
    check("sel_opd4", opd4, 32'd7);
    check("sel_rd", {26'd0, out_rd_we, out_rd_addr}, {26'd0, 1'b1, 5'd9});
    clear_in();
    step();

    // Forwarding at capture, while held, and never to address 0
    out_ready = 0;
    offer(32'd0, 32'h66);
    in_rs1_addr = 5'd4; in_rs2_addr = 5'd6;
    fwd_valid = 1; fwd_rd_addr = 5'd4; fwd_data = 32'hAA;
    step();
    check("fwd_cap_opd1", opd1, FWD ? 32'hAA : 32'd0);
    check("fwd_cap_opd4", opd4, 32'h66);
    clear_in();
    fwd_rd_addr = 5'd6; fwd_data = 32'h55;
    step();
    check("fwd_held_opd4", opd4, FWD ? 32'h55 : 32'h66);
    check("fwd_held_opd3", opd3, FWD ? 32'hAA : 32'd0);
    offer(32'h12, 32'h13);
    fwd_rd_addr = 5'd0; fwd_data = 32'h77;
    step();
    check("fwd_zero_head", opd1, FWD ? 32'hAA : 32'd0);
    fwd_valid = 0;
    clear_in();
    out_ready = 1;
    step();
    check("fwd_zero_skid", opd1, 32'h12);
    step();
    check("fwd_done", 32'(out_valid), 32'd0);

    // Flush in FULL with a simultaneous incoming instruction
    out_ready = 0;
    offer(32'h41, 32'h42);
    step();
    offer(32'h51, 32'h52);
    step();
    check("flush_pre_full", 32'(in_ready), 32'd0);
    offer(32'h61, 32'h62);
    flush = 1;
    step();
    flush = 0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    clear_in();
    out_ready = 1;
    step();
    check("flush_dropped", 32'(out_valid), 32'd0);

    // Reset mid-stall discards both entries
    out_ready = 0;
    offer(32'h71, 32'h72);
    step();
    offer(32'h81, 32'h82);
    step();
    clear_in();
    rst = 1;
    step();
    rst = 0;
    check("rst_stall_valid", 32'(out_valid), 32'd0);
    check("rst_stall_opd1", opd1, 32'd0);

    // Back-to-back streaming
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      offer(32'h40 + 32'(i), 32'(i));
      check("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_opd1", opd1, 32'h40 + 32'(i));
    end
    clear_in();
    step();
    check("stream_end", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue pipeline stage sitting directly upstream of `alu`: it registers one decoded instruction's operands and control fields and drives the ALU's `opd1`–`opd4`, `alu_mux1_select`, `alu_mux2_select` and `alu_op_select` from a registered head entry. A 2-entry skid buffer with valid/ready handshake on both sides decouples decode from execute stalls. Optional result forwarding patches stale register operands, both at capture and while an entry is held.

## Interface
- `OPERAND_LENGTH`, 32, data width of every operand, PC and immediate.
- `REG_ADDR_WIDTH`, 5, register-file address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode offers an instruction.
- `in_ready`  out  1  stage can accept; equals NOT skid-entry-valid.
- `in_rs1_val`, `in_rs2_val`, `in_pc`, `in_imm`  in  OPERAND_LENGTH each  source values, PC, immediate.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr`  in  REG_ADDR_WIDTH each  register addresses.
- `in_rd_we`  in  1  instruction writes `rd`.
- `in_use_pc`, `in_use_imm`  in  1 each  select PC for `opd1`, immediate for `opd2`.
- `in_mux1_sel` in 1, `in_mux2_sel` in 2, `in_op_sel` in 3  ALU control, passed through.
- `flush`  in  1  discard all held entries (branch redirect).
- `fwd_valid`  in  1  a result is being written back this cycle.
- `fwd_rd_addr`  in  REG_ADDR_WIDTH, `fwd_data`  in  OPERAND_LENGTH  forwarded destination and value.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  ALU/execute consumes head this cycle.
- `opd1`, `opd2`, `opd3`, `opd4`  out  OPERAND_LENGTH each  ALU operands.
- `alu_mux1_select` out 1, `alu_mux2_select` out 2, `alu_op_select` out 3  ALU control.
- `out_rd_addr` out REG_ADDR_WIDTH, `out_rd_we` out 1  destination passed downstream.

## Operation
- Two entries: HEAD (drives outputs) and SKID. Each stores rs1/rs2 values and addresses, pc, imm, rd, rd_we, use_pc, use_imm, mux/op selects.
- Output mapping from HEAD: `opd1` = use_pc ? pc : rs1; `opd2` = use_imm ? imm : rs2; `opd3` = rs1; `opd4` = rs2. Pure combinational from registers.
- Accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Occupancy states EMPTY, ONE (HEAD only), FULL (HEAD+SKID):
  - EMPTY: accept -> ONE.
  - ONE: accept & pop -> ONE (new data into HEAD); accept & !pop -> FULL (data into SKID); pop & !accept -> EMPTY.
  - FULL: `in_ready`=0; pop -> ONE, SKID moves to HEAD.
- Forwarding (when compiled in): a rs field matches if `fwd_valid` and `fwd_rd_addr` == its rs address and address != 0. Applies to incoming data at capture and to every valid held entry each cycle; matching field overwritten with `fwd_data`. Address 0 never forwarded.
- `flush`: next cycle EMPTY; overrides accept and pop in the same cycle (incoming instruction dropped).
- No arithmetic; widths pass through unchanged.

## Timing
- Reset: `out_valid`=0, `in_ready`=1, all data/control outputs 0; state EMPTY. Handshakes during `rst`=1 ignored.
- Latency: accepted at edge N -> `out_valid`=1 with its operands after edge N (visible cycle N+1).
- Throughput: one instruction/cycle when `out_ready` held high; `in_ready` never drops in that case.
- `in_ready` registered-state-derived; no combinational path from `out_ready`.
- HEAD payload stable while `out_valid & !out_ready`, except forwarding updates.
- Reset or flush mid-stall discards both entries; no partial output.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding logic as above.
- Undefined: `fwd_valid`, `fwd_rd_addr`, `fwd_data` ignored; operands are exactly captured values; all else identical.

## Test plan
- Reset then single issue: rs1=3, rs2=8, op_sel=000, mux2=00 -> next cycle `out_valid`=1, `opd1`=3, `opd2`=8, `opd3`=3, `opd4`=8.
- Stall: `out_ready`=0, issue two instr -> after second `in_ready`=0; third `in_valid` held; release `out_ready` -> outputs in order, no loss/duplication.
- Immediate/PC select: use_pc=1, pc=0x100, use_imm=1, imm=0x0C, rs1=5, rs2=7 -> `opd1`=0x100, `opd2`=0x0C, `opd3`=5, `opd4`=7.
- Forward at capture and while held (FWD_EN): rs1_addr=4, stale 0; `fwd_valid`, rd 4, data 0xAA same cycle -> `opd1`=0xAA; held entry with rs2_addr=6 gets fwd 0x55 during stall -> `opd4`=0x55; fwd to addr 0 -> no change.
- Flush in FULL with simultaneous `in_valid` -> next cycle `out_valid`=0, `in_ready`=1, new instr dropped.
- Back-to-back streaming 16 instrs, `out_ready`=1 -> 16 outputs on consecutive cycles, `in_ready` constantly 1.
